// File: rtl/lz77_div_pkg.sv
// Shared types and helpers for the time-multiplexed divider used by the
// LZ77 datapath: FSM state encoding, default sizes, round-robin pick.
package lz77_div_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_NREQ  = 4;
  localparam int RR_MAX    = 64;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  // First set bit of valid searching upward from last+1 with wrap at nreq.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input int nreq, input int last);
    rr_pick_t r;
    int       i;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      i = (last + k) % nreq;
      if (k <= nreq && !r.found && valid[i]) begin
        r.found = 1'b1;
        r.idx   = 8'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider, one quotient bit per cycle. Result registers only
// change on the final iteration or on a divide-by-zero start.
module div_iter_core
  import lz77_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem_p;
  logic [WIDTH-1:0] q_sh;
  logic [CW-1:0]    count;
  logic             active;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    shifted  = {rem_p[WIDTH-1:0], dvd_sh[WIDTH-1]};
    ge       = shifted >= {1'b0, dvs};
    rem_next = ge ? (shifted - {1'b0, dvs}) : shifted;
    q_next   = WIDTH'({q_sh, ge});
    done     = active && (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh <= '0;
      dvs    <= '0;
      rem_p  <= '0;
      q_sh   <= '0;
      count  <= '0;
      active <= 1'b0;
      quot   <= '0;
      rem    <= '0;
    end else if (start) begin
      dvd_sh <= dividend;
      dvs    <= divisor;
      rem_p  <= '0;
      q_sh   <= '0;
      count  <= '0;
      active <= (divisor != '0);
      if (divisor == '0) begin
        quot <= '1;
        rem  <= dividend;
      end
    end else if (active) begin
      dvd_sh <= dvd_sh << 1;
      rem_p  <= rem_next;
      q_sh   <= q_next;
      count  <= count + CW'(1);
      if (done) begin
        active <= 1'b0;
        quot   <= q_next;
        rem    <= rem_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin front end sharing one div_iter_core between NREQ requesters,
// with valid/ready handshakes on both the request and response sides.
module div_share_arbiter
  import lz77_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quot,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic                  rsp_div0,
  output logic                  busy
);

  localparam int IDW = $clog2(NREQ);

  state_t           state;
  state_t           next_state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   owner;
  logic             div0_q;
  rr_pick_t         pick;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic             core_done;

  always_comb begin
    pick         = rr_pick(RR_MAX'(req_valid), NREQ, int'(last_grant));
    grant_idx    = IDW'(pick.idx);
    accept       = (state == IDLE) && pick.found;
    sel_dividend = req_dividend[grant_idx*WIDTH +: WIDTH];
    sel_divisor  = req_divisor[grant_idx*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operands are captured only in the accept cycle; the pointer starts at
  // NREQ-1 so requester 0 wins the first arbitration after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
      owner      <= '0;
      div0_q     <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_idx;
      owner      <= grant_idx;
      div0_q     <= (sel_divisor == '0);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (sel_divisor == '0) ? DONE : ITER;
      ITER: if (core_done) next_state = DONE;
      DONE: if (rsp_ready[owner]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    if (state == DONE) rsp_valid[owner] = 1'b1;
    busy     = (state != IDLE);
    rsp_div0 = div0_q;
  end

  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend (sel_dividend),
    .divisor  (sel_divisor),
    .done     (core_done),
    .quot     (rsp_quot),
    .rem      (rsp_rem)
  );

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter at the default WIDTH=7, NREQ=4.
module tb_div_share_arbiter;

  localparam int W = 7;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   rsp_quot;
  logic [W-1:0]   rsp_rem;
  logic           rsp_div0;
  logic           busy;

  int checks = 0;
  int failures = 0;

  div_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quot     (rsp_quot),
    .rsp_rem      (rsp_rem),
    .rsp_div0     (rsp_div0),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int r, input int dvd, input int dvs);
    req_dividend[r*W +: W] = W'(dvd);
    req_divisor[r*W +: W]  = W'(dvs);
  endtask

  // Drives one complete operation for requester r and reports what came back.
  task automatic run_op(input int r, input int dvd, input int dvs,
                        output int lat, output int q, output int rm, output int d0);
    int n;
    set_req(r, dvd, dvs);
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 40) begin
      tick();
      n++;
    end
    tick();
    req_valid[r] = 1'b0;
    lat = 1;
    while (!rsp_valid[r] && lat < 30) begin
      tick();
      lat++;
    end
    q  = int'(rsp_quot);
    rm = int'(rsp_rem);
    d0 = int'(rsp_div0);
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (rsp_quot !== 7'd0 || rsp_rem !== 7'd0 || rsp_div0 !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_result got q=%0d r=%0d d0=%b want 0 0 0", rsp_quot, rsp_rem, rsp_div0);
    end
  endtask

  task automatic test_basic();
    int lat, q, rm, d0;
    run_op(0, 100, 7, lat, q, rm, d0);
    checks++; if (lat !== 8) begin failures++; $display("[TB] FAIL basic_latency got %0d want 8", lat); end
    checks++; if (q !== 14 || rm !== 2 || d0 !== 0) begin
      failures++; $display("[TB] FAIL basic_100_7 got q=%0d r=%0d d0=%0d want 14 2 0", q, rm, d0);
    end
    run_op(1, 127, 1, lat, q, rm, d0);
    checks++; if (q !== 127 || rm !== 0) begin failures++; $display("[TB] FAIL basic_127_1 got q=%0d r=%0d want 127 0", q, rm); end
    run_op(3, 5, 9, lat, q, rm, d0);
    checks++; if (q !== 0 || rm !== 5) begin failures++; $display("[TB] FAIL basic_5_9 got q=%0d r=%0d want 0 5", q, rm); end
  endtask

  task automatic test_div0();
    int lat, q, rm, d0;
    run_op(2, 45, 0, lat, q, rm, d0);
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL div0_latency got %0d want 1", lat); end
    checks++; if (q !== 127 || rm !== 45 || d0 !== 1) begin
      failures++; $display("[TB] FAIL div0_result got q=%0d r=%0d d0=%0d want 127 45 1", q, rm, d0);
    end
  endtask

  task automatic test_contention();
    int lat, q, rm, d0;
    do_reset();
    set_req(0, 20, 3);
    set_req(2, 50, 5);
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL contention_first got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    lat = 1;
    while (!rsp_valid[0] && lat < 30) begin
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL contention_busy_ready got %b want 0000", req_ready); end
      tick();
      lat++;
    end
    checks++; if (lat !== 8 || rsp_quot !== 7'd6 || rsp_rem !== 7'd2) begin
      failures++; $display("[TB] FAIL contention_op0 got lat=%0d q=%0d r=%0d want 8 6 2", lat, rsp_quot, rsp_rem);
    end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL contention_done_ready got %b want 0000", req_ready); end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL contention_second got %b want 0100", req_ready); end
    run_op(2, 50, 5, lat, q, rm, d0);
    checks++; if (q !== 10 || rm !== 0) begin failures++; $display("[TB] FAIL contention_op2 got q=%0d r=%0d want 10 0", q, rm); end
  endtask

  task automatic test_round_robin();
    int exp_q[4];
    int grants[4];
    int n, g, e;
    exp_q[0] = 10; exp_q[1] = 7; exp_q[2] = 5; exp_q[3] = 4;
    for (int i = 0; i < 4; i++) grants[i] = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 20 + i, 2 + i);
    req_valid = '1;
    rsp_ready = '1;
    #1;
    for (int k = 0; k < 12; k++) begin
      e = k % 4;
      n = 0;
      while (req_ready == '0 && n < 10) begin
        tick();
        n++;
      end
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (req_ready[i]) g = i;
      if (g >= 0) grants[g]++;
      checks++; if (req_ready !== 4'(1 << e)) begin
        failures++; $display("[TB] FAIL rr_grant op %0d got %b want %b", k, req_ready, 4'(1 << e));
      end
      tick();
      n = 0;
      while (rsp_valid == '0 && n < 30) begin
        tick();
        n++;
      end
      checks++; if (rsp_valid !== 4'(1 << e) || rsp_quot !== W'(exp_q[e])) begin
        failures++; $display("[TB] FAIL rr_result op %0d got v=%b q=%0d want v=%b q=%0d", k, rsp_valid, rsp_quot, 4'(1 << e), exp_q[e]);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (grants[i] !== 3) begin failures++; $display("[TB] FAIL rr_count req %0d got %0d want 3", i, grants[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    set_req(1, 90, 8);
    req_valid[1] = 1'b1;
    #1;
    tick();
    req_valid[1] = 1'b0;
    n = 0;
    while (!rsp_valid[1] && n < 30) begin
      tick();
      n++;
    end
    checks++; if (rsp_quot !== 7'd11 || rsp_rem !== 7'd2) begin
      failures++; $display("[TB] FAIL bp_result got q=%0d r=%0d want 11 2", rsp_quot, rsp_rem);
    end
    set_req(0, 9, 3);
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0010 || rsp_quot !== 7'd11 || rsp_rem !== 7'd2 || req_ready !== 4'b0000) begin
        failures++; $display("[TB] FAIL bp_hold cycle %0d got v=%b q=%0d r=%0d rdy=%b want 0010 11 2 0000", c, rsp_valid, rsp_quot, rsp_rem, req_ready);
      end
    end
    rsp_ready = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL bp_handshake_ready got %b want 0000", req_ready); end
    tick();
    rsp_ready = '0;
    checks++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin
      failures++; $display("[TB] FAIL bp_after got v=%b rdy=%b want 0000 0001", rsp_valid, req_ready);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int lat, q, rm, d0;
    run_op(2, 45, 0, lat, q, rm, d0);
    set_req(1, 64, 3);
    req_valid[1] = 1'b1;
    #1;
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1 || rsp_quot !== 7'd127) begin
      failures++; $display("[TB] FAIL mid_before got busy=%b q=%0d want 1 127", busy, rsp_quot);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
      failures++; $display("[TB] FAIL mid_ctrl got busy=%b v=%b rdy=%b want 0 0000 0000", busy, rsp_valid, req_ready);
    end
    checks++; if (rsp_quot !== 7'd0 || rsp_rem !== 7'd0 || rsp_div0 !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_result got q=%0d r=%0d d0=%b want 0 0 0", rsp_quot, rsp_rem, rsp_div0);
    end
    set_req(0, 8, 2);
    set_req(3, 9, 3);
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL mid_pointer got %b want 0001", req_ready); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
